// File: rtl/add16_seq_ctrl.sv
// add16_seq_ctrl
//   Wide (WORDS x 16-bit) adder built from one shared 16-bit ripple adder.
//   The adder processes one 16-bit slice per clock, least significant slice
//   first. The carry between slices is kept in a register. Operands enter
//   and the result leaves through valid/ready handshakes.
//
// Parameters
//   WORDS      number of 16-bit slices per operand (1..16), W = 16*WORDS
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and cin present
//   in_ready   block can accept operands (high only in IDLE)
//   a_in       operand A, W bits
//   b_in       operand B, W bits
//   cin        carry into slice 0
//   sub        (only with ADD16_SEQ_SUB_EN) 1 = compute a_in - b_in
//   out_valid  result present (high only in DONE)
//   out_ready  consumer accepts the result
//   sum_out    result, W bits
//   cout       carry out of the top slice (no-borrow flag when subtracting)
//
// Configuration
//   ADD16_SEQ_SUB_EN  when defined, adds the 'sub' port. sub=1 inverts the
//                     B slices and forces the initial carry to 1.

module add16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);

  logic [16:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 16; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[16];
  end

endmodule

module add16_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a_in,
  input  logic [16*WORDS-1:0]   b_in,
  input  logic                  cin,
`ifdef ADD16_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum_out,
  output logic                  cout
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  state_t         state_n;

  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [IW-1:0]  idx;
  logic           carry;
  logic           last;

  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [15:0]    a_sl;
  logic [15:0]    b_sl;
  logic [15:0]    s_sl;
  logic           co_sl;

`ifdef ADD16_SEQ_SUB_EN
  logic           sub_reg;
`endif

  assign last = (idx == IW'(WORDS - 1));

  // Shifting by idx*16 picks the current slice without an array index,
  // so non-power-of-two WORDS values never need an out-of-range guard.
  always_comb begin
    a_sh = a_reg >> {idx, 4'b0000};
    b_sh = b_reg >> {idx, 4'b0000};
    a_sl = a_sh[15:0];
    b_sl = b_sh[15:0];
`ifdef ADD16_SEQ_SUB_EN
    if (sub_reg) begin
      b_sl = ~b_sh[15:0];
    end
`endif
  end

  add16 u_add16 (
    .a  (a_sl),
    .b  (b_sl),
    .ci (carry),
    .s  (s_sl),
    .co (co_sl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Datapath: operands are captured on accept, then one slice of the sum
  // is written per RUN cycle. Nothing changes in DONE, so the result holds
  // stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
`ifdef ADD16_SEQ_SUB_EN
      sub_reg <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
            idx   <= '0;
`ifdef ADD16_SEQ_SUB_EN
            sub_reg <= sub;
            carry   <= sub ? 1'b1 : cin;
`else
            carry   <= cin;
`endif
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx == IW'(i)) begin
              sum_out[16*i +: 16] <= s_sl;
            end
          end
          carry <= co_sl;
          if (last) begin
            cout <= co_sl;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// tb_add16_seq_ctrl
//   Scoreboard bench for add16_seq_ctrl (WORDS = 4). The driver pushes the
//   arithmetic result expected for each accepted transaction. A monitor on
//   the falling edge pops and compares it whenever a result is handed over.
//   The same monitor checks latency, result stability under backpressure
//   and that in_ready stays low while a result is pending.

`timescale 1ns/1ps

module tb_add16_seq_ctrl;

  localparam int WORDS   = 4;
  localparam int W       = 16 * WORDS;
  localparam int TIMEOUT = 200;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a_in      = '0;
  logic [W-1:0]  b_in      = '0;
  logic          cin       = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum_out;
  logic          cout;
`ifdef ADD16_SEQ_SUB_EN
  logic          sub       = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    int           acceptCyc;
  } exp_t;

  exp_t          sbq[$];
  int            nChecks    = 0;
  int            nErrors    = 0;
  int            cyc        = 0;
  int            lastAccept = 0;
  bit            expectGap  = 1'b0;
  bit            randReady  = 1'b0;
  bit            prevValid  = 1'b0;
  logic [W-1:0]  prevSum    = '0;
  logic          prevCout   = 1'b0;

  add16_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
`ifdef ADD16_SEQ_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic countFail(input string name, input string detail);
    nChecks++;
    nErrors++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] randW();
    logic [W-1:0] v;
    int           pick;
    pick = $urandom_range(0, 7);
    v    = '0;
    for (int i = 0; i < WORDS; i++) begin
      v[16*i +: 16] = 16'($urandom);
    end
    if (pick == 0) v = '1;
    if (pick == 1) v = '0;
    return v;
  endfunction

  // Drives one transaction and records the expected result. Expected values
  // come from whole-word arithmetic on the operands, not from slices.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic s);
    int          waitCnt;
    exp_t        e;
    logic [W:0]  full;
    waitCnt = 0;
    @(posedge clk); #1;
    while (!in_ready && waitCnt < TIMEOUT) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!in_ready) begin
      countFail("accept_timeout", "got in_ready=0 expected 1");
      return;
    end
    a_in     = a;
    b_in     = b;
    cin      = ci;
`ifdef ADD16_SEQ_SUB_EN
    sub      = s;
`endif
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in     = randW();
    b_in     = randW();
    cin      = 1'($urandom);
    if (s) begin
      e.sum = a - b;
      e.co  = (a >= b);
    end else begin
      full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      e.sum = full[W-1:0];
      e.co  = full[W];
    end
    e.acceptCyc = cyc;
    if (expectGap) begin
      checkInt("accept_gap", cyc - lastAccept, WORDS + 2);
    end
    lastAccept = cyc;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= TIMEOUT) begin
      countFail("drain_timeout", "got pending result expected none");
    end
  endtask

  // Random out_ready generator, active only while randReady is set.
  always @(posedge clk) begin
    #1;
    if (randReady) begin
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) begin
        checkBit("in_ready_low_in_done", in_ready, 1'b0);
        if (!prevValid) begin
          if (sbq.size() == 0) begin
            countFail("unexpected_out_valid", "got out_valid=1 expected 0");
          end else begin
            checkInt("latency", cyc - sbq[0].acceptCyc, WORDS);
          end
        end else begin
          checkOutput("sum_stable", sum_out, prevSum);
          checkBit("cout_stable", cout, prevCout);
        end
        if (out_ready) begin
          if (sbq.size() == 0) begin
            countFail("result_without_request", "got result expected none");
          end else begin
            e = sbq.pop_front();
            checkOutput("sum", sum_out, e.sum);
            checkBit("cout", cout, e.co);
          end
        end
      end
      prevValid = out_valid;
      prevSum   = sum_out;
      prevCout  = cout;
    end else begin
      prevValid = 1'b0;
    end
  end

  initial begin
    int n;
    $display("[TB] start, WORDS=%0d", WORDS);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkBit("reset_in_ready", in_ready, 1'b1);
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_sum_out", sum_out, '0);
    checkBit("reset_cout", cout, 1'b0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // All ones plus carry-in wraps to zero with carry out.
    applyStimulus({W{1'b1}}, '0, 1'b1, 1'b0);
    drain();
    // Carry crosses from slice 0 into slice 1 only.
    applyStimulus(64'h0001_0002_0003_0004, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
    drain();

    // Backpressure: result must hold while out_ready is low.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(randW(), randW(), 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < TIMEOUT) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) countFail("bp_wait_valid", "got out_valid=0 expected 1");
    repeat (5) begin
      @(posedge clk); #1;
      a_in     = randW();
      in_valid = ~in_valid;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkBit("bp_release_out_valid", out_valid, 1'b0);
    checkBit("bp_release_in_ready", in_ready, 1'b1);
    drain();

    // Reset in the second RUN cycle discards the transaction.
    $display("[TB] reset mid-operation");
    applyStimulus(randW() | 64'h1, 64'h1, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkBit("midreset_out_valid", out_valid, 1'b0);
    checkBit("midreset_in_ready", in_ready, 1'b1);
    checkOutput("midreset_sum_out", sum_out, '0);
    checkBit("midreset_cout", cout, 1'b0);
    sbq.delete();
    repeat (WORDS + 2) @(posedge clk);
    #1;
    checkBit("midreset_no_result", out_valid, 1'b0);
    rst_n = 1'b1;
    applyStimulus(64'h1, 64'h1, 1'b0, 1'b0);
    drain();

`ifdef ADD16_SEQ_SUB_EN
    $display("[TB] subtract");
    applyStimulus(64'h10, 64'h11, 1'b0, 1'b1);
    drain();
    applyStimulus(64'h11, 64'h10, 1'b1, 1'b1);
    drain();
`endif

    // Back-to-back transactions at best throughput.
    $display("[TB] back-to-back");
    applyStimulus(64'hFFFF, 64'h0001, 1'b0, 1'b0);
    expectGap = 1'b1;
    applyStimulus(randW(), randW(), 1'b0, 1'b0);
    applyStimulus(randW(), randW(), 1'b1, 1'b0);
    expectGap = 1'b0;
    drain();

    // Randomized traffic with random consumer backpressure.
    $display("[TB] random");
    randReady = 1'b1;
    for (int t = 0; t < 40; t++) begin
`ifdef ADD16_SEQ_SUB_EN
      applyStimulus(randW(), randW(), 1'($urandom), 1'($urandom));
`else
      applyStimulus(randW(), randW(), 1'($urandom), 1'b0);
`endif
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
